// File: rtl/nanov_shift_deser.sv
// nanov_shift_deser: bit-serial result deserializer for the nanoV datapath.
// Takes one result bit per qualified cycle, LSB first. It returns the current
// bit index to the upstream stage as `counter`. When a word is complete it
// publishes the word with a one-cycle `done` pulse and a registered zero flag.
module nanov_shift_deser #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             d_in,
  input  logic             d_valid,
  output logic [CW-1:0]    counter,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      counter_q, counter_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sr_shift;
  logic               last_bit;

  // New bits enter at the MSB, so after WIDTH bits bit 0 sits in sr[0].
  assign sr_shift = {d_in, sr_q[WIDTH-1:1]};
  assign last_bit = (counter_q == CW'(WIDTH - 1));

  // Next-state logic: abort beats start, and start beats an ordinary capture.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    sr_d      = sr_q;
    result_d  = result_q;
    zero_d    = zero_q;
    done_d    = 1'b0;
    if (abort) begin
      state_d   = IDLE;
      counter_d = '0;
    end else if (start) begin
      // A restart discards any partial word. The incoming bit can be bit 0.
      state_d   = CAPTURE;
      counter_d = '0;
      if (d_valid) begin
        sr_d      = sr_shift;
        counter_d = CW'(1);
      end
    end else if (state_q == CAPTURE && d_valid) begin
      sr_d = sr_shift;
      if (last_bit) begin
        result_d  = sr_shift;
        zero_d    = (sr_shift == '0);
        done_d    = 1'b1;
        counter_d = '0;
        state_d   = IDLE;
      end else begin
        counter_d = counter_q + CW'(1);
      end
    end
  end

  // State and datapath registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      counter_q <= '0;
      sr_q      <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      sr_q      <= sr_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      done_q    <= done_d;
    end
  end

  assign counter = counter_q;
  assign busy    = (state_q == CAPTURE);
  assign done    = done_q;
  assign result  = result_q;
  assign zero    = zero_q;

endmodule

// File: tb/tb_nanov_shift_deser.sv
// Testbench for nanov_shift_deser. The reference model tracks the word as an
// indexed bit array plus a bit count, and is stepped once per clock edge.
module tb_nanov_shift_deser;

  localparam int WIDTH = 32;
  localparam int CW    = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst, start, abort, d_in, d_valid;
  logic [CW-1:0]    counter;
  logic             busy, done, zero;
  logic [WIDTH-1:0] result;

  int n_assert = 0;
  int n_fail   = 0;
  int done_seen;

  // Reference model state
  bit              m_active;
  int              m_cnt;
  logic [WIDTH-1:0] m_word;
  logic [WIDTH-1:0] m_result;
  bit              m_done;

  nanov_shift_deser #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .d_in    (d_in),
    .d_valid (d_valid),
    .counter (counter),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .zero    (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge, using the inputs that were applied.
  task automatic model_edge(input bit r, input bit st, input bit ab, input bit dv, input bit di);
    m_done = 1'b0;
    if (r) begin
      m_active = 1'b0; m_cnt = 0; m_word = '0; m_result = '0;
    end else if (ab) begin
      m_active = 1'b0; m_cnt = 0;
    end else if (st) begin
      m_active = 1'b1; m_cnt = 0; m_word = '0;
      if (dv) begin
        m_word[0] = di; m_cnt = 1;
      end
    end else if (m_active && dv) begin
      m_word[m_cnt] = di;
      if (m_cnt == WIDTH - 1) begin
        m_result = m_word; m_done = 1'b1; m_active = 1'b0; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  // One clock cycle: apply inputs, clock, update model, check all outputs.
  task automatic step(input bit r, input bit st, input bit ab, input bit dv, input bit di);
    rst = r; start = st; abort = ab; d_valid = dv; d_in = di;
    @(posedge clk);
    model_edge(r, st, ab, dv, di);
    #1;
    if (done === 1'b1) done_seen++;
    chk("counter", 32'(counter), 32'(m_cnt));
    chk("busy",    32'(busy),    32'(m_active));
    chk("done",    32'(done),    32'(m_done));
    chk("result",  result,       m_result);
    chk("zero",    32'(zero),    32'(m_result == '0));
  endtask

  // Stream a full word LSB first; optionally insert a stall after each bit.
  task automatic send_word(input logic [WIDTH-1:0] w, input bit stall);
    for (int i = 0; i < WIDTH; i++) begin
      step(1'b0, (i == 0), 1'b0, 1'b1, w[i]);
      if (stall && i != WIDTH - 1) begin
        chk("stall_counter_before", 32'(counter), 32'(i + 1));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom));
        chk("stall_counter_hold", 32'(counter), 32'(i + 1));
        if (i < WIDTH - 2) chk("stall_result_hold", result, 32'h12345678);
      end
    end
  endtask

  initial begin
    m_active = 0; m_cnt = 0; m_word = '0; m_result = '0; m_done = 0;
    done_seen = 0;
    rst = 1; start = 0; abort = 0; d_in = 0; d_valid = 0;

    // Power-on reset
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Reset asserted mid-word with start held
    send_word(32'hCAFEF00D, 0);
    for (int i = 0; i < 10; i++) step(0, (i == 0), 0, 1, 1'($urandom));
    step(1, 1, 0, 1, 1);
    step(1, 1, 0, 1, 1);
    chk("rst_result",  result, 32'h0);
    chk("rst_zero",    32'(zero), 32'd1);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_counter", 32'(counter), 32'd0);
    chk("rst_done",    32'(done), 32'd0);

    // Continuous word
    begin
      logic [31:0] w;
      w = 32'hA5A50F01;
      for (int i = 0; i < WIDTH; i++) begin
        step(0, (i == 0), 0, 1, w[i]);
        if (i < WIDTH - 1) begin
          chk("cont_counter", 32'(counter), 32'(i + 1));
          chk("cont_no_done", 32'(done), 32'd0);
        end
      end
    end
    chk("cont_done",   32'(done), 32'd1);
    chk("cont_result", result, 32'hA5A50F01);
    chk("cont_zero",   32'(zero), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("cont_done_pulse", 32'(done), 32'd0);

    // Stall pattern, with a known prior result
    send_word(32'h12345678, 0);
    send_word(32'h80000001, 1);
    chk("stall_done",   32'(done), 32'd1);
    chk("stall_result", result, 32'h80000001);
    step(0, 0, 0, 0, 0);

    // Abort at counter = 10
    send_word(32'h12345678, 0);
    for (int i = 0; i < 10; i++) step(0, (i == 0), 0, 1, 1'($urandom));
    chk("abort_pre_counter", 32'(counter), 32'd10);
    done_seen = 0;
    step(0, 0, 1, 1, 1);
    chk("abort_busy",    32'(busy), 32'd0);
    chk("abort_counter", 32'(counter), 32'd0);
    for (int i = 0; i < 40; i++) step(0, 0, 0, 1'($urandom), 1'($urandom));
    step(0, 1, 1, 1, 1);
    chk("abort_start_busy", 32'(busy), 32'd0);
    chk("abort_no_done",    32'(done_seen), 32'd0);
    chk("abort_result",     result, 32'h12345678);

    // Restart at counter = 20
    for (int i = 0; i < 20; i++) step(0, (i == 0), 0, 1, 0);
    chk("restart_pre_counter", 32'(counter), 32'd20);
    done_seen = 0;
    send_word(32'hFFFFFFFF, 0);
    chk("restart_done",   32'(done), 32'd1);
    chk("restart_count",  32'(done_seen), 32'd1);
    chk("restart_result", result, 32'hFFFFFFFF);

    // Back-to-back: start in the done cycle of the previous word
    step(0, 0, 0, 0, 0);
    send_word(32'hDEADBEEF, 0);
    chk("b2b_first", result, 32'hDEADBEEF);
    done_seen = 0;
    send_word(32'h00000000, 0);
    chk("b2b_done",   32'(done), 32'd1);
    chk("b2b_count",  32'(done_seen), 32'd1);
    chk("b2b_result", result, 32'h0);
    chk("b2b_zero",   32'(zero), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      step((r == 0), (r >= 1 && r <= 3), (r == 4), ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/nanov_shift_deser.md
# nanov_shift_deser

Bit-serial result deserializer for the nanoV datapath. It sits at the output of the bit-serial shift/ALU stage and consumes one result bit per qualified cycle, LSB first. It drives the bit index back to that stage as `counter` and assembles a 32-bit word for register writeback. It signals completion with a one-cycle `done` pulse and holds the assembled word stable until the next word completes.

## Interface
Parameters:
- `WIDTH`, 32, word width; must be a power of two; `CW = $clog2(WIDTH)`

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  begin a new word; `d_in` in this cycle is bit 0 if `d_valid`=1
- `abort`  in  1  cancel the current word; no `done`, `result` unchanged
- `d_in`  in  1  serial result bit, LSB first
- `d_valid`  in  1  qualifies `d_in`; 0 = stall, counter holds
- `counter`  out  CW  index of the bit captured on the next qualified cycle
- `busy`  out  1  word capture in progress
- `done`  out  1  one-cycle pulse; `result` is the new word in this cycle
- `result`  out  WIDTH  last completed word
- `zero`  out  1  registered flag, `result == 0`

## Operation
- State: IDLE or CAPTURE. `busy` = (state == CAPTURE).
- Internal shift register `sr[WIDTH-1:0]`. A qualified bit shifts in at the MSB, with `sr <= {d_in, sr[WIDTH-1:1]}`. After WIDTH bits the word is aligned, with bit 0 at `sr[0]`.
- IDLE:
  - `start`=1 with `d_valid`=1: capture bit 0, `counter`→1, go to CAPTURE.
  - `start`=1 with `d_valid`=0: go to CAPTURE, `counter` stays 0.
  - `d_valid` without `start` is ignored.
- CAPTURE:
  - Each `d_valid`=1 cycle: capture `d_in`, `counter` += 1.
  - `d_valid`=0: hold everything.
- Completion: the qualified cycle with `counter` = WIDTH-1 captures the last bit. On that edge:
  - `result <= {d_in, sr[WIDTH-1:1]}`
  - `zero` updates to match the new `result`
  - `done <= 1` for exactly one cycle
  - `counter <= 0`, state → IDLE
- `counter` wraps WIDTH-1 → 0 only at completion. It never exceeds WIDTH-1.
- `start` during CAPTURE restarts the word:
  - The partial word is discarded and `counter` goes to 0.
  - The same `d_valid`/`d_in` rules as IDLE apply, so `d_in` is captured as bit 0 if `d_valid`=1.
  - `start` in the completing cycle also restarts. No `done` is produced for the interrupted word.
- `abort`:
  - In any state: state → IDLE, `counter` → 0.
  - `result`, `zero`, `done` are unaffected (no new `done`).
  - `abort` and `start` in the same cycle: `abort` wins, `start` is ignored.
- `result` and `zero` change only at completion or reset, never mid-capture.

## Timing
- Reset (`rst`=1 at edge):
  - state IDLE, `counter`=0, `busy`=0, `done`=0
  - `result`=0, `zero`=1, `sr`=0
  - `rst` overrides `start` and `abort`, and may be asserted mid-word.
- Latency with `start` and `d_valid` both asserted at cycle 0 and `d_valid` held high:
  - bits 0..WIDTH-1 are captured in cycles 0..WIDTH-1
  - `done`=1 and the new `result` appear in cycle WIDTH (32)
- Each stalled cycle adds exactly one cycle of latency.
- `counter` is registered. The upstream stage indexes bit `counter` combinationally in the same cycle.
- The `done` cycle is in IDLE, so `start` may be asserted in the `done` cycle for back-to-back words with no bubble.
- `busy` falls in the `done` cycle and rises the cycle after an accepted `start`.

## Test plan
- Reset: assert `rst` for 2 cycles mid-word. Required: `result`=0x00000000, `zero`=1, `busy`=0, `counter`=0, `done`=0. `start` held during reset has no effect.
- Continuous word: `start`+`d_valid` at cycle 0, stream 0xA5A50F01 LSB first. Required:
  - `counter` reads 1..31 over cycles 1..31
  - `done`=1 only in cycle 32, with `result`=0xA5A50F01 and `zero`=0
- Stall: stream 0x80000001 with `d_valid` toggling 1,0,1,0…. Required:
  - `counter` holds on every stall cycle
  - `done` appears one cycle after the 32nd qualified bit; `result`=0x80000001
  - `result` keeps its old value until then
- Abort: prior `result`=0x12345678. Start a new word and assert `abort` at `counter`=10. Required:
  - next cycle `busy`=0, `counter`=0
  - no `done`; `result` stays 0x12345678
  - `abort`+`start` together leave `busy`=0
- Restart: start 0x00000000, then assert `start` again at `counter`=20 and stream 0xFFFFFFFF. Required:
  - exactly one `done`, 32 cycles after the restart
  - `result`=0xFFFFFFFF
- Back-to-back: complete 0xDEADBEEF, then assert `start` in its `done` cycle and stream 0x00000000. Required:
  - second `done` 32 cycles later
  - `result`=0x00000000, `zero`=1
